wt_dcache_rd_miss_arb: RTL and testbench

- Downstream stage of the per-port dcache read controllers. Takes their read-miss requests, round-robin arbitrates them, and keeps one miss status holding register (MSHR) per port.
- Detects cache-line collisions with outstanding misses, picks the victim way, issues one memory read at a time, and routes memory returns to the cache write port and the owning read port.

---
 rtl/wt_dcache_rd_miss_arb.sv | 182 ++++++++++++++++++
 tb/tb_wt_dcache_rd_miss_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_rd_miss_arb.sv
// Read-miss arbiter for the write-through dcache: round-robin over the read ports,
// one MSHR per port, a single memory issue register, and return routing to the cache write port.
module wt_dcache_rd_miss_arb #(
   parameter int NumPorts  = 3,
   parameter int PlenWidth = 56,
   parameter int TagWidth  = 44,
   parameter int IdxWidth  = 8,
   parameter int OffWidth  = 4,
   parameter int SetAssoc  = 8,
   parameter int LineWidth = 128
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumPorts-1:0]           miss_req_i,
   input  logic [NumPorts*PlenWidth-1:0] miss_paddr_i,
   input  logic [NumPorts*3-1:0]         miss_size_i,
   input  logic [NumPorts-1:0]           miss_nc_i,
   input  logic [NumPorts*SetAssoc-1:0]  miss_vld_bits_i,
   output logic [NumPorts-1:0]           miss_ack_o,
   output logic [NumPorts-1:0]           miss_replay_o,
   output logic [NumPorts-1:0]           miss_rtrn_vld_o,
   output logic [LineWidth-1:0]          rtrn_data_o,
   output logic                          mem_req_vld_o,
   input  logic                          mem_req_rdy_i,
   output logic [PlenWidth-1:0]          mem_req_paddr_o,
   output logic [2:0]                    mem_req_size_o,
   output logic                          mem_req_nc_o,
   output logic [$clog2(NumPorts)-1:0]   mem_req_id_o,
   input  logic                          mem_rtrn_vld_i,
   input  logic [$clog2(NumPorts)-1:0]   mem_rtrn_id_i,
   input  logic [LineWidth-1:0]          mem_rtrn_data_i,
   output logic                          wr_cl_vld_o,
   output logic [SetAssoc-1:0]           wr_cl_we_o,
   output logic [IdxWidth-1:0]           wr_cl_idx_o,
   output logic [TagWidth-1:0]           wr_cl_tag_o,
   output logic [LineWidth-1:0]          wr_cl_data_o,
   output logic                          busy_o
);
   localparam int IdW   = $clog2(NumPorts);
   localparam int WayW  = $clog2(SetAssoc);
   localparam int LineW = PlenWidth - OffWidth;

   // Handshake: a port holds miss_req_i until it sees miss_ack_o or miss_replay_o for one cycle;
   // mem_req_vld_o holds until a cycle with mem_req_rdy_i=1, which completes the transfer.

   logic [NumPorts-1:0][PlenWidth-1:0] req_paddr;
   logic [NumPorts-1:0][2:0]           req_size;
   logic [NumPorts-1:0][SetAssoc-1:0]  req_vbits;
   assign req_paddr = miss_paddr_i;
   assign req_size  = miss_size_i;
   assign req_vbits = miss_vld_bits_i;

   logic [NumPorts-1:0]            mshr_vld, mshr_nc;
   logic [NumPorts-1:0][LineW-1:0] mshr_line;
   logic [NumPorts-1:0][WayW-1:0]  mshr_way;

   logic                 iss_vld, iss_nc;
   logic [PlenWidth-1:0] iss_paddr;
   logic [2:0]           iss_size;
   logic [IdW-1:0]       iss_id;

   logic [IdW-1:0]  rr_ptr;
   logic [WayW-1:0] repl_cnt;

   logic                 gnt_vld, gnt_nc, gnt_ack, gnt_replay, coll;
   logic [IdW-1:0]       gnt_idx;
   logic [PlenWidth-1:0] gnt_paddr;
   logic [2:0]           gnt_size;
   logic [SetAssoc-1:0]  gnt_vbits;
   logic                 vict_free;
   logic [WayW-1:0]      vict;
   logic                 rtrn_hit;
   logic [NumPorts-1:0]  clr;

   function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NumPorts;
      return IdW'(s);
   endfunction

   // Descending scan so the port closest to rr_ptr overwrites the others.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = NumPorts-1; k >= 0; k--) begin
         if (miss_req_i[rr_idx(rr_ptr, k)]) begin
            gnt_vld = ~rst_i;
            gnt_idx = rr_idx(rr_ptr, k);
         end
      end
   end

   assign gnt_paddr = req_paddr[gnt_idx];
   assign gnt_size  = req_size[gnt_idx];
   assign gnt_vbits = req_vbits[gnt_idx];
   assign gnt_nc    = miss_nc_i[gnt_idx];

   assign rtrn_hit = mem_rtrn_vld_i && (int'(mem_rtrn_id_i) < NumPorts) && mshr_vld[mem_rtrn_id_i];
   assign clr      = rtrn_hit ? (NumPorts'(1) << mem_rtrn_id_i) : '0;

   // An MSHR being retired this cycle no longer blocks its line.
   always_comb begin
      coll = 1'b0;
      for (int m = 0; m < NumPorts; m++) begin
         if (mshr_vld[m] && !mshr_nc[m] && !clr[m] &&
             mshr_line[m] == gnt_paddr[PlenWidth-1:OffWidth])
            coll = 1'b1;
      end
   end

   always_comb begin
      vict_free = 1'b0;
      vict      = repl_cnt;
      for (int w = SetAssoc-1; w >= 0; w--) begin
         if (!gnt_vbits[w]) begin
            vict_free = 1'b1;
            vict      = WayW'(w);
         end
      end
   end

   assign gnt_replay = gnt_vld && !gnt_nc && coll;
   assign gnt_ack    = gnt_vld && !gnt_replay && (!iss_vld || mem_req_rdy_i);

   assign miss_ack_o    = gnt_ack    ? (NumPorts'(1) << gnt_idx) : '0;
   assign miss_replay_o = gnt_replay ? (NumPorts'(1) << gnt_idx) : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mshr_vld  <= '0;
         mshr_nc   <= '0;
         mshr_line <= '0;
         mshr_way  <= '0;
         iss_vld   <= 1'b0;
         iss_nc    <= 1'b0;
         iss_paddr <= '0;
         iss_size  <= '0;
         iss_id    <= '0;
         rr_ptr    <= '0;
         repl_cnt  <= '0;
      end else begin
         if (iss_vld && mem_req_rdy_i) iss_vld <= 1'b0;
         if (rtrn_hit) mshr_vld[mem_rtrn_id_i] <= 1'b0;
         if (gnt_ack || gnt_replay)
            rr_ptr <= (gnt_idx == IdW'(NumPorts-1)) ? '0 : gnt_idx + 1'b1;
         if (gnt_ack) begin
            iss_vld   <= 1'b1;
            iss_nc    <= gnt_nc;
            iss_id    <= gnt_idx;
            iss_paddr <= gnt_nc ? gnt_paddr : {gnt_paddr[PlenWidth-1:OffWidth], {OffWidth{1'b0}}};
            iss_size  <= gnt_nc ? gnt_size : 3'b111;
            mshr_vld[gnt_idx]  <= 1'b1;
            mshr_nc[gnt_idx]   <= gnt_nc;
            mshr_line[gnt_idx] <= gnt_paddr[PlenWidth-1:OffWidth];
            mshr_way[gnt_idx]  <= vict;
            if (!vict_free)
               repl_cnt <= (repl_cnt == WayW'(SetAssoc-1)) ? '0 : repl_cnt + 1'b1;
         end
      end
   end

   assign mem_req_vld_o   = iss_vld;
   assign mem_req_paddr_o = iss_paddr;
   assign mem_req_size_o  = iss_size;
   assign mem_req_nc_o    = iss_nc;
   assign mem_req_id_o    = iss_id;

   assign miss_rtrn_vld_o = clr;
   assign rtrn_data_o     = rtrn_hit ? mem_rtrn_data_i : '0;
   assign wr_cl_vld_o     = rtrn_hit && !mshr_nc[mem_rtrn_id_i];
   assign wr_cl_we_o      = wr_cl_vld_o ? (SetAssoc'(1) << mshr_way[mem_rtrn_id_i]) : '0;
   assign wr_cl_idx_o     = wr_cl_vld_o ? mshr_line[mem_rtrn_id_i][IdxWidth-1:0] : '0;
   assign wr_cl_tag_o     = wr_cl_vld_o ? mshr_line[mem_rtrn_id_i][LineW-1 -: TagWidth] : '0;
   assign wr_cl_data_o    = wr_cl_vld_o ? mem_rtrn_data_i : '0;

   assign busy_o = (|mshr_vld) || iss_vld;

   assert property (@(posedge clk_i) disable iff (rst_i) (miss_req_i & mshr_vld) == '0)
      else $error("miss request from a port whose MSHR is still valid");
   assert property (@(posedge clk_i) disable iff (rst_i) mem_rtrn_vld_i |-> rtrn_hit)
      else $error("memory return to an invalid MSHR");
endmodule

// File: tb/tb_wt_dcache_rd_miss_arb.sv
// Scenario bench for wt_dcache_rd_miss_arb: expected memory requests go into exp_q at ack time
// and are popped when the issue register presents them.
module tb_wt_dcache_rd_miss_arb;
   localparam int NP = 3, PW = 56, SA = 8, LW = 128, MW = 62;

   logic clk = 1'b0, rst = 1'b1;
   logic [NP-1:0]          req = '0, nc = '0;
   logic [NP-1:0][PW-1:0]  paddr_a = '0;
   logic [NP-1:0][2:0]     size_a = '0;
   logic [NP-1:0][SA-1:0]  vbits_a = '0;
   logic                   mem_rdy = 1'b0, rtrn_vld = 1'b0;
   logic [1:0]             rtrn_id = '0;
   logic [LW-1:0]          rtrn_data = '0;

   logic [NP-1:0] miss_ack, miss_replay, miss_rtrn_vld;
   logic [LW-1:0] rtrn_data_o, wr_cl_data;
   logic          mem_req_vld, mem_req_nc, wr_cl_vld, busy;
   logic [PW-1:0] mem_req_paddr;
   logic [2:0]    mem_req_size;
   logic [1:0]    mem_req_id;
   logic [SA-1:0] wr_cl_we;
   logic [7:0]    wr_cl_idx;
   logic [43:0]   wr_cl_tag;

   int n_checks = 0, n_errors = 0;
   logic [MW-1:0] exp_q[$];
   logic [MW-1:0] exp_m;
   logic [LW-1:0] data_a, data_b;

   always #5 clk = ~clk;

   wt_dcache_rd_miss_arb dut (
      .clk_i(clk), .rst_i(rst),
      .miss_req_i(req), .miss_paddr_i(paddr_a), .miss_size_i(size_a), .miss_nc_i(nc),
      .miss_vld_bits_i(vbits_a),
      .miss_ack_o(miss_ack), .miss_replay_o(miss_replay), .miss_rtrn_vld_o(miss_rtrn_vld),
      .rtrn_data_o(rtrn_data_o),
      .mem_req_vld_o(mem_req_vld), .mem_req_rdy_i(mem_rdy), .mem_req_paddr_o(mem_req_paddr),
      .mem_req_size_o(mem_req_size), .mem_req_nc_o(mem_req_nc), .mem_req_id_o(mem_req_id),
      .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_id_i(rtrn_id), .mem_rtrn_data_i(rtrn_data),
      .wr_cl_vld_o(wr_cl_vld), .wr_cl_we_o(wr_cl_we), .wr_cl_idx_o(wr_cl_idx),
      .wr_cl_tag_o(wr_cl_tag), .wr_cl_data_o(wr_cl_data), .busy_o(busy)
   );

   // ---------------- driver tasks (called at posedge + 1) ----------------
   task automatic drive_req(input int p, input logic [PW-1:0] a, input logic [2:0] s,
                            input logic n, input logic [SA-1:0] vb);
      req[p] = 1'b1; paddr_a[p] = a; size_a[p] = s; nc[p] = n; vbits_a[p] = vb;
   endtask

   task automatic start_rtrn(input logic [1:0] id, input logic [LW-1:0] d);
      rtrn_vld = 1'b1; rtrn_id = id; rtrn_data = d;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; req = '0; nc = '0; mem_rdy = 1'b0; rtrn_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic logic [LW-1:0] rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      req = 3'b111; vbits_a = '1; paddr_a[0] = 56'h8000_0000; start_rtrn(2'd0, rand_line());
      #12;
      n_checks++;
      if ({miss_ack, miss_replay, miss_rtrn_vld} !== 9'b0) begin
         n_errors++; $display("FAIL reset_port_outs: got %b required 0", {miss_ack, miss_replay, miss_rtrn_vld});
      end
      n_checks++;
      if ({mem_req_vld, wr_cl_vld, busy, wr_cl_we} !== 11'b0 || rtrn_data_o !== '0) begin
         n_errors++; $display("FAIL reset_mem_outs: got vld=%b wr=%b busy=%b we=%h", mem_req_vld, wr_cl_vld, busy, wr_cl_we);
      end
      apply_reset();
   endtask

   task automatic test_single();
      apply_reset();
      drive_req(0, 56'h8000_1234, 3'b011, 1'b0, 8'b1111_0111);
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b001) begin n_errors++; $display("FAIL single_ack: got %b required 001", miss_ack); end
      exp_q.push_back({1'b0, 2'd0, 3'b111, 56'h8000_1230});
      next_cycle(); req[0] = 1'b0; mem_rdy = 1'b1;
      @(negedge clk);
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL single_memreq: got vld=%b %h required %h", mem_req_vld, {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      next_cycle(); mem_rdy = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req_vld !== 1'b0 || busy !== 1'b1) begin
         n_errors++; $display("FAIL single_drained: got vld=%b busy=%b required 0 1", mem_req_vld, busy);
      end
      data_a = rand_line();
      next_cycle(); start_rtrn(2'd0, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b001 || rtrn_data_o !== data_a || wr_cl_data !== data_a) begin
         n_errors++; $display("FAIL single_rtrn: got rtrn_vld=%b data=%h", miss_rtrn_vld, rtrn_data_o);
      end
      n_checks++;
      if ({wr_cl_vld, wr_cl_we, wr_cl_idx, wr_cl_tag} !== {1'b1, 8'b0000_1000, 8'h23, 44'h80001}) begin
         n_errors++; $display("FAIL single_wrcl: got vld=%b we=%b idx=%h tag=%h required 1 00001000 23 80001", wr_cl_vld, wr_cl_we, wr_cl_idx, wr_cl_tag);
      end
      next_cycle(); rtrn_vld = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL single_idle: got busy=%b required 0", busy); end
      next_cycle();
   endtask

   task automatic test_rr_hold();
      apply_reset();
      drive_req(0, 56'h8000_2000, 3'b111, 1'b0, 8'h00);
      drive_req(1, 56'h8000_3000, 3'b111, 1'b0, 8'h00);
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b001) begin n_errors++; $display("FAIL rr_first_ack: got %b required 001", miss_ack); end
      exp_q.push_back({1'b0, 2'd0, 3'b111, 56'h8000_2000});
      next_cycle(); req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b000 || miss_replay !== 3'b000) begin
         n_errors++; $display("FAIL rr_held: got ack=%b replay=%b required 000 000", miss_ack, miss_replay);
      end
      next_cycle(); mem_rdy = 1'b1;
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b010) begin n_errors++; $display("FAIL rr_drain_ack: got %b required 010", miss_ack); end
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL rr_memreq0: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      exp_q.push_back({1'b0, 2'd1, 3'b111, 56'h8000_3000});
      next_cycle(); req[1] = 1'b0;
      @(negedge clk);
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL rr_memreq1: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      data_a = rand_line(); data_b = rand_line();
      next_cycle(); mem_rdy = 1'b0; start_rtrn(2'd1, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b010 || {wr_cl_vld, wr_cl_we, wr_cl_tag} !== {1'b1, 8'h01, 44'h80003} || rtrn_data_o !== data_a) begin
         n_errors++; $display("FAIL rr_rtrn1: got rtrn_vld=%b we=%b tag=%h", miss_rtrn_vld, wr_cl_we, wr_cl_tag);
      end
      next_cycle(); start_rtrn(2'd0, data_b);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b001 || {wr_cl_vld, wr_cl_we, wr_cl_tag} !== {1'b1, 8'h01, 44'h80002} || rtrn_data_o !== data_b) begin
         n_errors++; $display("FAIL rr_rtrn0: got rtrn_vld=%b we=%b tag=%h", miss_rtrn_vld, wr_cl_we, wr_cl_tag);
      end
      next_cycle(); rtrn_vld = 1'b0;
      drive_req(0, 56'h8000_4000, 3'b111, 1'b0, 8'h00);
      drive_req(1, 56'h8000_5000, 3'b111, 1'b0, 8'h00);
      drive_req(2, 56'h8000_6000, 3'b111, 1'b0, 8'h00);
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b100) begin n_errors++; $display("FAIL rr_ptr_at_2: got %b required 100", miss_ack); end
      exp_q.push_back({1'b0, 2'd2, 3'b111, 56'h8000_6000});
      next_cycle(); req = '0; mem_rdy = 1'b1;
      @(negedge clk);
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL rr_memreq2: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      next_cycle(); mem_rdy = 1'b0; start_rtrn(2'd2, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b100) begin n_errors++; $display("FAIL rr_rtrn2: got %b required 100", miss_rtrn_vld); end
      next_cycle(); rtrn_vld = 1'b0;
   endtask

   task automatic test_collision();
      apply_reset();
      drive_req(0, 56'h8000_1234, 3'b011, 1'b0, 8'h00);
      mem_rdy = 1'b1;
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b001) begin n_errors++; $display("FAIL coll_ack0: got %b required 001", miss_ack); end
      exp_q.push_back({1'b0, 2'd0, 3'b111, 56'h8000_1230});
      next_cycle(); req[0] = 1'b0;
      @(negedge clk);
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL coll_memreq0: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      next_cycle(); mem_rdy = 1'b0;
      drive_req(2, 56'h8000_1238, 3'b011, 1'b0, 8'b0000_0011);
      @(negedge clk);
      n_checks++;
      if (miss_replay !== 3'b100 || miss_ack !== 3'b000) begin
         n_errors++; $display("FAIL coll_replay: got replay=%b ack=%b required 100 000", miss_replay, miss_ack);
      end
      next_cycle(); req[2] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req_vld !== 1'b0 || busy !== 1'b1) begin
         n_errors++; $display("FAIL coll_no_memreq: got vld=%b busy=%b required 0 1", mem_req_vld, busy);
      end
      next_cycle();
   endtask

   task automatic test_collision_clear();
      data_a = rand_line();
      drive_req(2, 56'h8000_1238, 3'b011, 1'b0, 8'b0000_0011);
      start_rtrn(2'd0, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b100 || miss_replay !== 3'b000) begin
         n_errors++; $display("FAIL clr_ack: got ack=%b replay=%b required 100 000", miss_ack, miss_replay);
      end
      n_checks++;
      if (miss_rtrn_vld !== 3'b001 || {wr_cl_vld, wr_cl_we, wr_cl_idx, wr_cl_tag} !== {1'b1, 8'h01, 8'h23, 44'h80001}) begin
         n_errors++; $display("FAIL clr_wrcl: got rtrn_vld=%b vld=%b we=%b idx=%h tag=%h", miss_rtrn_vld, wr_cl_vld, wr_cl_we, wr_cl_idx, wr_cl_tag);
      end
      exp_q.push_back({1'b0, 2'd2, 3'b111, 56'h8000_1230});
      next_cycle(); req[2] = 1'b0; rtrn_vld = 1'b0; mem_rdy = 1'b1;
      @(negedge clk);
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL clr_memreq2: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      next_cycle(); mem_rdy = 1'b0; start_rtrn(2'd2, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b100 || wr_cl_we !== 8'b0000_0100 || wr_cl_idx !== 8'h23) begin
         n_errors++; $display("FAIL clr_rtrn2: got rtrn_vld=%b we=%b idx=%h required 100 00000100 23", miss_rtrn_vld, wr_cl_we, wr_cl_idx);
      end
      next_cycle(); rtrn_vld = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL clr_idle: got busy=%b required 0", busy); end
      next_cycle();
   endtask

   task automatic test_nc();
      apply_reset();
      drive_req(1, 56'h1000_0004, 3'b010, 1'b1, 8'h00);
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b010) begin n_errors++; $display("FAIL nc_ack: got %b required 010", miss_ack); end
      exp_q.push_back({1'b1, 2'd1, 3'b010, 56'h1000_0004});
      next_cycle(); req[1] = 1'b0; mem_rdy = 1'b1;
      drive_req(0, 56'h1000_0008, 3'b011, 1'b0, 8'h00);
      @(negedge clk);
      n_checks++;
      if (miss_ack !== 3'b001 || miss_replay !== 3'b000) begin
         n_errors++; $display("FAIL nc_no_compare: got ack=%b replay=%b required 001 000", miss_ack, miss_replay);
      end
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL nc_memreq: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      exp_q.push_back({1'b0, 2'd0, 3'b111, 56'h1000_0000});
      next_cycle(); req[0] = 1'b0;
      @(negedge clk);
      exp_m = exp_q.pop_front();
      n_checks++;
      if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL nc_memreq_c: got %h required %h", {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
      end
      data_a = rand_line();
      next_cycle(); mem_rdy = 1'b0; start_rtrn(2'd1, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b010 || wr_cl_vld !== 1'b0 || rtrn_data_o !== data_a) begin
         n_errors++; $display("FAIL nc_rtrn: got rtrn_vld=%b wr_cl_vld=%b required 010 0", miss_rtrn_vld, wr_cl_vld);
      end
      next_cycle(); start_rtrn(2'd0, data_a);
      @(negedge clk);
      n_checks++;
      if (miss_rtrn_vld !== 3'b001 || {wr_cl_vld, wr_cl_idx, wr_cl_tag} !== {1'b1, 8'h00, 44'h10000}) begin
         n_errors++; $display("FAIL nc_rtrn_c: got rtrn_vld=%b vld=%b idx=%h tag=%h", miss_rtrn_vld, wr_cl_vld, wr_cl_idx, wr_cl_tag);
      end
      next_cycle(); rtrn_vld = 1'b0;
   endtask

   task automatic test_victim_cnt();
      int order[3] = '{2, 0, 1};
      apply_reset();
      mem_rdy = 1'b1;
      for (int p = 0; p < NP; p++) begin
         drive_req(p, 56'h8000_5000 + 56'(p) * 56'h1000, 3'b111, 1'b0, 8'hFF);
         @(negedge clk);
         n_checks++;
         if (miss_ack !== 3'(1 << p)) begin n_errors++; $display("FAIL vict_ack%0d: got %b", p, miss_ack); end
         exp_q.push_back({1'b0, 2'(p), 3'b111, 56'h8000_5000 + 56'(p) * 56'h1000});
         next_cycle(); req[p] = 1'b0;
         @(negedge clk);
         exp_m = exp_q.pop_front();
         n_checks++;
         if ({mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr} !== exp_m || mem_req_vld !== 1'b1) begin
            n_errors++; $display("FAIL vict_memreq%0d: got %h required %h", p, {mem_req_nc, mem_req_id, mem_req_size, mem_req_paddr}, exp_m);
         end
         next_cycle();
      end
      mem_rdy = 1'b0;
      for (int i = 0; i < NP; i++) begin
         start_rtrn(2'(order[i]), rand_line());
         @(negedge clk);
         n_checks++;
         if (miss_rtrn_vld !== 3'(1 << order[i]) || wr_cl_we !== 8'(1 << order[i]) ||
             wr_cl_tag !== 44'h80005 + 44'(order[i])) begin
            n_errors++; $display("FAIL vict_way%0d: got rtrn_vld=%b we=%b tag=%h", order[i], miss_rtrn_vld, wr_cl_we, wr_cl_tag);
         end
         next_cycle(); rtrn_vld = 1'b0;
      end
   endtask

   task automatic test_reset_busy();
      apply_reset();
      drive_req(0, 56'h8000_9000, 3'b111, 1'b0, 8'h00);
      @(negedge clk);
      next_cycle(); req[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || mem_req_vld !== 1'b1) begin
         n_errors++; $display("FAIL rstb_pre: got busy=%b vld=%b required 1 1", busy, mem_req_vld);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || mem_req_vld !== 1'b0) begin
         n_errors++; $display("FAIL rstb_async: got busy=%b vld=%b required 0 0", busy, mem_req_vld);
      end
      start_rtrn(2'd0, rand_line());
      #1;
      n_checks++;
      if (miss_rtrn_vld !== 3'b000 || wr_cl_vld !== 1'b0 || rtrn_data_o !== '0) begin
         n_errors++; $display("FAIL rstb_rtrn_ignored: got rtrn_vld=%b wr_cl_vld=%b required 000 0", miss_rtrn_vld, wr_cl_vld);
      end
      rtrn_vld = 1'b0;
      next_cycle(); rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || mem_req_vld !== 1'b0) begin
         n_errors++; $display("FAIL rstb_post: got busy=%b vld=%b required 0 0", busy, mem_req_vld);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_rr_hold();
      test_collision();
      test_collision_clear();
      test_nc();
      test_victim_cnt();
      test_reset_busy();
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_errors++; $display("FAIL scoreboard_empty: got %0d entries required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
